// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared definitions for the VGA timing generator: the default 640x480@60
//   timing constants, their derived totals and sync windows, the counter type,
//   and the 3-bit sync bundle carried through the optional sync delay line.
//   Used by vga_timing_gen and vga_delay_line.
package vga_timing_pkg;

    localparam int CNT_W     = 11;
    localparam int MAX_COUNT = 2047;

    typedef logic [CNT_W-1:0] cnt_t;

    // Default horizontal timing, in pixels.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    // Default vertical timing, in lines.
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_PIPE_DELAY = 3;

    // Derived defaults: 800 x 525 totals, sync low on x 656..751 and y 490..491.
    localparam int DEF_H_TOTAL    = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL    = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_HS_START   = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_HS_END     = DEF_HS_START + DEF_H_SYNC;
    localparam int DEF_VS_START   = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_VS_END     = DEF_VS_START + DEF_V_SYNC;

    // Sync bundle; hs/vs are active-low, blank_n is high in the active area.
    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

    // Half-open window test lo <= v < hi, all 11-bit unsigned.
    function automatic logic in_window(input cnt_t v, input cnt_t lo, input cnt_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line
//   DEPTH-stage shift register for the 3-bit sync bundle. Advances only on
//   pixel ticks so the delay is counted in pixels, and resets to the idle
//   sync pattern so the display sees no spurious sync while it refills.
// Ports:
//   iCLK    - clock, rising edge
//   iRST    - synchronous active-high reset (fills all stages with SYNC_IDLE)
//   tick_en - pixel-tick enable
//   d       - sync bundle entering the line
//   q       - sync bundle delayed by DEPTH ticks
module vga_delay_line
    import vga_timing_pkg::*;
#(
    parameter int DEPTH = DEF_PIPE_DELAY
) (
    input  logic  iCLK,
    input  logic  iRST,
    input  logic  tick_en,
    input  sync_t d,
    output sync_t q
);

    sync_t stage_q [DEPTH];

    // NOTE: storage arrays are normally left unreset; this one is only a few
    // flops and must come out of reset holding idle sync, so every stage is reset.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= SYNC_IDLE;
            end
        end else if (tick_en) begin
            stage_q[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   VGA raster timing: x/y counters, active flag, line/frame start pulses and
//   active-low HS/VS with a blank_n display enable. All state advances only
//   on cycles with iPIX_EN=1.
//   Build option: define VGA_SYNC_DELAY_EN to delay oHS/oVS/oBlank_N by
//   PIPE_DELAY pixel ticks (vga_delay_line) so they line up with a pixel
//   pipeline; undefined, they are aligned with the counters.
// Ports:
//   iCLK, iRST            - clock; synchronous active-high reset
//   iPIX_EN               - pixel-tick enable
//   oVga_x, oVga_y        - 11-bit pixel / line counters
//   oActive               - visible area flag (never delayed)
//   oLine_Start           - one-cycle pulse when x wraps to 0
//   oFrame_Start          - one-cycle pulse when x and y wrap to 0
//   oHS, oVS              - active-low syncs
//   oBlank_N              - display enable
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int PIPE_DELAY = DEF_PIPE_DELAY
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iPIX_EN,
    output logic [CNT_W-1:0]  oVga_x,
    output logic [CNT_W-1:0]  oVga_y,
    output logic              oActive,
    output logic              oLine_Start,
    output logic              oFrame_Start,
    output logic              oHS,
    output logic              oVS,
    output logic              oBlank_N
);

    localparam int H_TOTAL_I = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL_I = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam cnt_t H_LAST   = cnt_t'(H_TOTAL_I - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_TOTAL_I - 1);
    localparam cnt_t H_ACT    = cnt_t'(H_ACTIVE);
    localparam cnt_t V_ACT    = cnt_t'(V_ACTIVE);
    localparam cnt_t HS_START = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t VS_START = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (H_TOTAL_I > MAX_COUNT || V_TOTAL_I > MAX_COUNT || PIPE_DELAY < 1) begin : g_param_check
            $error("vga_timing_gen: totals must fit 11 bits and PIPE_DELAY must be >= 1");
        end
    endgenerate

    cnt_t  x_q, y_q, x_nxt, y_nxt;
    logic  started_q;
    logic  active_q, line_q, frame_q;
    logic  line_wrap, frame_wrap;
    sync_t sync_q, sync_nxt;

    // Next raster position. Out of reset the first tick re-presents (0,0) and
    // flags it as a frame start instead of stepping to x=1.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the branches can leave one unassigned and infer a latch.
        x_nxt      = x_q + cnt_t'(1);
        y_nxt      = y_q;
        line_wrap  = 1'b0;
        frame_wrap = 1'b0;
        if (!started_q) begin
            x_nxt      = '0;
            y_nxt      = '0;
            line_wrap  = 1'b1;
            frame_wrap = 1'b1;
        end else if (x_q == H_LAST) begin
            x_nxt     = '0;
            line_wrap = 1'b1;
            if (y_q == V_LAST) begin
                y_nxt      = '0;
                frame_wrap = 1'b1;
            end else begin
                y_nxt = y_q + cnt_t'(1);
            end
        end

        sync_nxt.hs      = !in_window(x_nxt, HS_START, HS_END);
        sync_nxt.vs      = !in_window(y_nxt, VS_START, VS_END);
        sync_nxt.blank_n = (x_nxt < H_ACT) && (y_nxt < V_ACT);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            x_q       <= '0;
            y_q       <= '0;
            started_q <= 1'b0;
            active_q  <= 1'b0;
            line_q    <= 1'b0;
            frame_q   <= 1'b0;
            sync_q    <= SYNC_IDLE;
        end else begin
            // Pulses last one iCLK cycle; non-tick edges clear them.
            line_q  <= 1'b0;
            frame_q <= 1'b0;
            if (iPIX_EN) begin
                x_q       <= x_nxt;
                y_q       <= y_nxt;
                started_q <= 1'b1;
                active_q  <= sync_nxt.blank_n;
                line_q    <= line_wrap;
                frame_q   <= frame_wrap;
                sync_q    <= sync_nxt;
            end
        end
    end

    assign oVga_x       = x_q;
    assign oVga_y       = y_q;
    assign oActive      = active_q;
    assign oLine_Start  = line_q;
    assign oFrame_Start = frame_q;

`ifdef VGA_SYNC_DELAY_EN
    sync_t sync_dly;

    vga_delay_line #(
        .DEPTH (PIPE_DELAY)
    ) u_sync_dly (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .tick_en (iPIX_EN),
        .d       (sync_q),
        .q       (sync_dly)
    );

    assign oHS      = sync_dly.hs;
    assign oVS      = sync_dly.vs;
    assign oBlank_N = sync_dly.blank_n;
`else
    assign oHS      = sync_q.hs;
    assign oVS      = sync_q.vs;
    assign oBlank_N = sync_q.blank_n;
`endif

endmodule
